contador_sel_frec_param: RTL and testbench

//  Parametrised up/down selector counter driven by raw push-buttons; generation-2 frequency selector for the DPWM.

---
 rtl/contador_sel_frec_param_if.sv | 33 +++
 rtl/contador_sel_frec_param.sv | 132 +++++++++++++
 tb/tb_contador_sel_frec_param.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_sel_frec_param_if.sv
// rtl/contador_sel_frec_param_if.sv - button/load/count bundle of the frequency selector counter
// Purpose: groups the selector's control inputs and count/status outputs.
// Signals:
//   boton_aumento, boton_disminuye  raw push-buttons, active high
//   enable                          accept button steps
//   carga, valor_carga              one-cycle preset load strobe and value
//   numero_frec                     current count
//   cambio                          pulse in the first cycle of a new count
//   en_min, en_max                  count sits at the lower / upper limit
// Modports: master drives buttons/enable/load, slave is the counter.
interface contador_sel_frec_param_if #(
  parameter int WIDTH = 3
);
  logic             boton_aumento;
  logic             boton_disminuye;
  logic             enable;
  logic             carga;
  logic [WIDTH-1:0] valor_carga;
  logic [WIDTH-1:0] numero_frec;
  logic             cambio;
  logic             en_min;
  logic             en_max;

  modport master (
    output boton_aumento, boton_disminuye, enable, carga, valor_carga,
    input  numero_frec, cambio, en_min, en_max
  );

  modport slave (
    input  boton_aumento, boton_disminuye, enable, carga, valor_carga,
    output numero_frec, cambio, en_min, en_max
  );
endinterface

// File: rtl/contador_sel_frec_param.sv
// rtl/contador_sel_frec_param.sv - debounced up/down frequency selector counter for the DPWM
// Purpose: synchronises and debounces two raw buttons, turns each clean press into one
//   up/down step and keeps the count in [MIN_VAL,MAX_VAL] (wrap or saturate), with a
//   synchronous clamped preset load that has priority over steps.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous reset, active low
//   bus      slave side of contador_sel_frec_param_if (buttons, enable, load, count, status)
module contador_sel_frec_param #(
  parameter int WIDTH      = 3,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 7,
  parameter int RESET_VAL  = 0,
  parameter int DEB_CYCLES = 16,
  parameter int WRAP       = 1
) (
  input logic                     clk,
  input logic                     reset_n,
  contador_sel_frec_param_if.slave bus
);

  localparam int             CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_LIM = CW'(DEB_CYCLES);
  // Limits held one bit wider than the count so +1 at 2**WIDTH-1 is seen as out of range
  localparam logic [WIDTH:0] MIN_E   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_E   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] RST_E   = (WIDTH+1)'(RESET_VAL);
  localparam logic [WIDTH:0] ONE_E   = (WIDTH+1)'(1);

  // Index 0 = up button, index 1 = down button
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [CW-1:0] deb_cnt [2];

  logic             step_up;
  logic             step_dn;
  logic [WIDTH-1:0] count_q;
  logic             cambio_q;
  logic [WIDTH:0]   cnt_e;
  logic [WIDTH:0]   load_e;
  logic [WIDTH:0]   clamp_e;
  logic [WIDTH:0]   inc_e;
  logic [WIDTH:0]   dec_e;

  assign raw = {bus.boton_disminuye, bus.boton_aumento};

  // Synchroniser plus debounce: the level is only accepted after DEB_CYCLES consecutive
  // cycles of disagreement; any cycle of agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LIM) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  // One step per debounced press; releases produce nothing
  assign step_up = deb[0] & ~deb_d[0];
  assign step_dn = deb[1] & ~deb_d[1];

  assign cnt_e  = {1'b0, count_q};
  assign load_e = {1'b0, bus.valor_carga};
  assign inc_e  = cnt_e + ONE_E;
  assign dec_e  = cnt_e - ONE_E;  // underflow from 0 lands above MAX_E

  always_comb begin
    clamp_e = load_e;
    if (load_e < MIN_E)      clamp_e = MIN_E;
    else if (load_e > MAX_E) clamp_e = MAX_E;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= RST_E[WIDTH-1:0];
      cambio_q <= 1'b0;
    end else begin
      cambio_q <= 1'b0;
      if (bus.carga) begin
        count_q  <= clamp_e[WIDTH-1:0];
        cambio_q <= (clamp_e != cnt_e);
      end else if (bus.enable && (step_up ^ step_dn)) begin
        // Simultaneous up and down cancel out via the XOR above
        if (step_up) begin
          if (inc_e > MAX_E) begin
            if (WRAP != 0) begin
              count_q  <= MIN_E[WIDTH-1:0];
              cambio_q <= 1'b1;
            end
          end else begin
            count_q  <= inc_e[WIDTH-1:0];
            cambio_q <= 1'b1;
          end
        end else begin
          if ((dec_e < MIN_E) || (dec_e > MAX_E)) begin
            if (WRAP != 0) begin
              count_q  <= MAX_E[WIDTH-1:0];
              cambio_q <= 1'b1;
            end
          end else begin
            count_q  <= dec_e[WIDTH-1:0];
            cambio_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.numero_frec = count_q;
  assign bus.cambio      = cambio_q;
  assign bus.en_min      = (cnt_e == MIN_E);
  assign bus.en_max      = (cnt_e == MAX_E);

endmodule

// File: tb/tb_contador_sel_frec_param.sv
// tb/tb_contador_sel_frec_param.sv - directed self-checking bench for contador_sel_frec_param
module tb_contador_sel_frec_param;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  // a: wrap, 0..7   s: saturate, 0..7   m: wrap, 0..5
  contador_sel_frec_param_if #(.WIDTH(3)) if_a ();
  contador_sel_frec_param_if #(.WIDTH(3)) if_s ();
  contador_sel_frec_param_if #(.WIDTH(3)) if_m ();

  contador_sel_frec_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .RESET_VAL(0),
                            .DEB_CYCLES(4), .WRAP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  contador_sel_frec_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .RESET_VAL(0),
                            .DEB_CYCLES(4), .WRAP(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(if_s));
  contador_sel_frec_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(5), .RESET_VAL(0),
                            .DEB_CYCLES(4), .WRAP(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(if_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int d, input bit up, input bit dn);
    case (d)
      0: begin if_a.boton_aumento = up; if_a.boton_disminuye = dn; end
      1: begin if_s.boton_aumento = up; if_s.boton_disminuye = dn; end
      default: begin if_m.boton_aumento = up; if_m.boton_disminuye = dn; end
    endcase
  endtask

  function automatic logic get_cambio(input int d);
    case (d)
      0: return if_a.cambio;
      1: return if_s.cambio;
      default: return if_m.cambio;
    endcase
  endfunction

  function automatic logic [2:0] get_count(input int d);
    case (d)
      0: return if_a.numero_frec;
      1: return if_s.numero_frec;
      default: return if_m.numero_frec;
    endcase
  endfunction

  // Load on the next edge; returns at the negedge after it, when outputs show the load
  task automatic load(input int d, input logic [2:0] v);
    case (d)
      0: begin if_a.carga = 1'b1; if_a.valor_carga = v; end
      1: begin if_s.carga = 1'b1; if_s.valor_carga = v; end
      default: begin if_m.carga = 1'b1; if_m.valor_carga = v; end
    endcase
    @(negedge clk);
    if_a.carga = 1'b0;
    if_s.carga = 1'b0;
    if_m.carga = 1'b0;
  endtask

  // Clean press held for 'hold' cycles, then released and settled; counts cambio pulses
  task automatic press(input int d, input bit up, input bit dn, input int hold, output int pulses);
    pulses = 0;
    drive(d, up, dn);
    repeat (hold) begin
      @(negedge clk);
      if (get_cambio(d) === 1'b1) pulses++;
    end
    drive(d, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (get_cambio(d) === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (if_a.numero_frec !== 3'd0 || if_a.cambio !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d cambio=%0b expected count=0 cambio=0", if_a.numero_frec, if_a.cambio);
    end
    checks++;
    if (if_a.en_min !== 1'b1 || if_a.en_max !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: en_min=%0b en_max=%0b expected 1 0", if_a.en_min, if_a.en_max);
    end
    if_a.carga = 1'b1;
    if_a.valor_carga = 3'd5;
    @(posedge clk);
    #2;
    checks++;
    if (if_a.numero_frec !== 3'd5 || if_a.cambio !== 1'b1) begin
      errors++;
      $display("FAIL load5_before_reset: count=%0d cambio=%0b expected 5 1", if_a.numero_frec, if_a.cambio);
    end
    if_a.carga = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (if_a.numero_frec !== 3'd0 || if_a.cambio !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d cambio=%0b expected 0 0", if_a.numero_frec, if_a.cambio);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (if_a.numero_frec !== 3'd0) begin
      errors++;
      $display("FAIL after_reset_release: count=%0d expected 0", if_a.numero_frec);
    end
  endtask

  task automatic test_debounce;
    int pulses;
    pulses = 0;
    // 3-cycle glitch is shorter than the 4-cycle debounce window
    drive(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 1'b0);
    repeat (15) begin
      @(negedge clk);
      if (if_a.cambio === 1'b1) pulses++;
    end
    checks++;
    if (if_a.numero_frec !== 3'd0 || pulses != 0) begin
      errors++;
      $display("FAIL glitch: count=%0d pulses=%0d expected 0 0", if_a.numero_frec, pulses);
    end
    // Bounce 1,0,1,0 then stable high from the edge after this drive (edge t)
    drive(0, 1'b1, 1'b0); @(negedge clk);
    drive(0, 1'b0, 1'b0); @(negedge clk);
    drive(0, 1'b1, 1'b0); @(negedge clk);
    drive(0, 1'b0, 1'b0); @(negedge clk);
    drive(0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (if_a.numero_frec !== 3'd0 || if_a.cambio !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: count=%0d cambio=%0b expected 0 0 at t+6", if_a.numero_frec, if_a.cambio);
        end
      end
      if (k == 7) begin
        checks++;
        if (if_a.numero_frec !== 3'd1 || if_a.cambio !== 1'b1) begin
          errors++;
          $display("FAIL latency_edge: count=%0d cambio=%0b expected 1 1 at t+7", if_a.numero_frec, if_a.cambio);
        end
      end
      if (k == 8) begin
        checks++;
        if (if_a.cambio !== 1'b0) begin
          errors++;
          $display("FAIL cambio_width: cambio=%0b expected 0 at t+8", if_a.cambio);
        end
      end
    end
    pulses = 0;
    drive(0, 1'b0, 1'b0); @(negedge clk);
    drive(0, 1'b1, 1'b0); @(negedge clk);
    drive(0, 1'b0, 1'b0); @(negedge clk);
    drive(0, 1'b1, 1'b0); @(negedge clk);
    drive(0, 1'b0, 1'b0);
    repeat (15) begin
      @(negedge clk);
      if (if_a.cambio === 1'b1) pulses++;
    end
    checks++;
    if (if_a.numero_frec !== 3'd1 || pulses != 0) begin
      errors++;
      $display("FAIL release_bounce: count=%0d pulses=%0d expected 1 0", if_a.numero_frec, pulses);
    end
  endtask

  task automatic test_wrap_saturate;
    int pulses;
    load(0, 3'd7);
    checks++;
    if (if_a.numero_frec !== 3'd7 || if_a.en_max !== 1'b1) begin
      errors++;
      $display("FAIL load7: count=%0d en_max=%0b expected 7 1", if_a.numero_frec, if_a.en_max);
    end
    press(0, 1'b1, 1'b0, 8, pulses);
    checks++;
    if (if_a.numero_frec !== 3'd0 || pulses != 1 || if_a.en_min !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: count=%0d pulses=%0d en_min=%0b expected 0 1 1", if_a.numero_frec, pulses, if_a.en_min);
    end
    press(0, 1'b0, 1'b1, 8, pulses);
    checks++;
    if (if_a.numero_frec !== 3'd7 || pulses != 1 || if_a.en_max !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: count=%0d pulses=%0d en_max=%0b expected 7 1 1", if_a.numero_frec, pulses, if_a.en_max);
    end
    load(1, 3'd7);
    press(1, 1'b1, 1'b0, 8, pulses);
    checks++;
    if (if_s.numero_frec !== 3'd7 || pulses != 0 || if_s.en_max !== 1'b1) begin
      errors++;
      $display("FAIL saturate_up: count=%0d pulses=%0d en_max=%0b expected 7 0 1", if_s.numero_frec, pulses, if_s.en_max);
    end
    press(1, 1'b0, 1'b1, 8, pulses);
    checks++;
    if (if_s.numero_frec !== 3'd6 || pulses != 1) begin
      errors++;
      $display("FAIL saturate_down_step: count=%0d pulses=%0d expected 6 1", if_s.numero_frec, pulses);
    end
    press(1, 1'b0, 1'b0, 1, pulses);
    load(1, 3'd0);
    press(1, 1'b0, 1'b1, 8, pulses);
    checks++;
    if (if_s.numero_frec !== 3'd0 || pulses != 0) begin
      errors++;
      $display("FAIL saturate_down_min: count=%0d pulses=%0d expected 0 0", if_s.numero_frec, pulses);
    end
  endtask

  task automatic test_both_buttons;
    int pulses;
    press(0, 1'b1, 1'b1, 8, pulses);
    checks++;
    if (if_a.numero_frec !== 3'd7 || pulses != 0) begin
      errors++;
      $display("FAIL both_buttons: count=%0d pulses=%0d expected 7 0", if_a.numero_frec, pulses);
    end
  endtask

  task automatic test_enable;
    int pulses;
    load(0, 3'd2);
    pulses = 0;
    if_a.enable = 1'b0;
    drive(0, 1'b1, 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (if_a.cambio === 1'b1) pulses++;
    end
    if_a.enable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (if_a.cambio === 1'b1) pulses++;
    end
    drive(0, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (if_a.cambio === 1'b1) pulses++;
    end
    checks++;
    if (if_a.numero_frec !== 3'd2 || pulses != 0) begin
      errors++;
      $display("FAIL step_dropped: count=%0d pulses=%0d expected 2 0", if_a.numero_frec, pulses);
    end
    press(0, 1'b1, 1'b0, 8, pulses);
    checks++;
    if (if_a.numero_frec !== 3'd3 || pulses != 1) begin
      errors++;
      $display("FAIL enabled_step: count=%0d pulses=%0d expected 3 1", if_a.numero_frec, pulses);
    end
  endtask

  task automatic test_load;
    int pulses;
    load(2, 3'd6);
    checks++;
    if (if_m.numero_frec !== 3'd5 || if_m.cambio !== 1'b1 || if_m.en_max !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp: count=%0d cambio=%0b en_max=%0b expected 5 1 1", if_m.numero_frec, if_m.cambio, if_m.en_max);
    end
    // Up press stable from edge t steps at edge t+7; load lands on that same edge
    drive(2, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    load(2, 3'd3);
    checks++;
    if (if_m.numero_frec !== 3'd3 || if_m.cambio !== 1'b1) begin
      errors++;
      $display("FAIL load_over_step: count=%0d cambio=%0b expected 3 1", if_m.numero_frec, if_m.cambio);
    end
    pulses = 0;
    drive(2, 1'b0, 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (if_m.cambio === 1'b1) pulses++;
    end
    checks++;
    if (if_m.numero_frec !== 3'd3 || pulses != 0) begin
      errors++;
      $display("FAIL step_discarded: count=%0d pulses=%0d expected 3 0", if_m.numero_frec, pulses);
    end
    load(2, 3'd3);
    checks++;
    if (if_m.numero_frec !== 3'd3 || if_m.cambio !== 1'b0) begin
      errors++;
      $display("FAIL load_same: count=%0d cambio=%0b expected 3 0", if_m.numero_frec, if_m.cambio);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    if_a.boton_aumento = 1'b0; if_a.boton_disminuye = 1'b0; if_a.enable = 1'b1;
    if_a.carga = 1'b0; if_a.valor_carga = 3'd0;
    if_s.boton_aumento = 1'b0; if_s.boton_disminuye = 1'b0; if_s.enable = 1'b1;
    if_s.carga = 1'b0; if_s.valor_carga = 3'd0;
    if_m.boton_aumento = 1'b0; if_m.boton_disminuye = 1'b0; if_m.enable = 1'b1;
    if_m.carga = 1'b0; if_m.valor_carga = 3'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_debounce();
    test_wrap_saturate();
    test_both_buttons();
    test_enable();
    test_load();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
